// File: rtl/seq_expr_calc_if.sv
// seq_expr_calc_if: token input and result output bundle of the calculator.
// master = token source / result sink (front-end), slave = seq_expr_calc.
interface seq_expr_calc_if #(
    parameter int W = 8
);
    logic         CLEAR;
    logic         IN_VALID;
    logic         IN_READY;
    logic [W-1:0] IN_MAG;
    logic         IN_NEG;
    logic [1:0]   IN_OP;
    logic         IN_LAST;
    logic [W-1:0] RES_MAG;
    logic         RES_NEG;
    logic         RES_VALID;
    logic         BUSY;
    logic         FLAG_ZERO;
    logic         FLAG_DIVZ;
    logic         FLAG_OVF;

    modport master (
        output CLEAR, IN_VALID, IN_MAG, IN_NEG, IN_OP, IN_LAST,
        input  IN_READY, RES_MAG, RES_NEG, RES_VALID, BUSY,
        input  FLAG_ZERO, FLAG_DIVZ, FLAG_OVF
    );

    modport slave (
        input  CLEAR, IN_VALID, IN_MAG, IN_NEG, IN_OP, IN_LAST,
        output IN_READY, RES_MAG, RES_NEG, RES_VALID, BUSY,
        output FLAG_ZERO, FLAG_DIVZ, FLAG_OVF
    );
endinterface

// File: rtl/seq_expr_calc.sv
// seq_expr_calc: sequential sign-magnitude expression calculator (+ - * /).
// Ports: CLOCK_50, RESET_N (async low), bus = token in / result + flags out.
module seq_expr_calc #(
    parameter int W       = 8,
    parameter int N_OPS   = 5,
    parameter bit PREC_EN = 1'b1
) (
    input logic            CLOCK_50,
    input logic            RESET_N,
    seq_expr_calc_if.slave bus
);
    localparam int SW = W + 2;
    localparam int PW = 2 * W + 2;
    localparam int IW = $clog2(W) + 1;
    localparam logic [W-1:0]  MAXV = {W{1'b1}};
    localparam logic [3:0]    NOPS = 4'(N_OPS);
    localparam logic [IW-1:0] ITL  = IW'(W - 1);
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_ACCEPT, S_MUL, S_DIV, S_FOLD, S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] sum_q, sum_d, term_q, term_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          last_q, last_d, neg_q, neg_d;
    logic          divz_q, divz_d, ovf_q, ovf_d;
    logic [PW-1:0] acc_q, acc_d, mcand_q, mcand_d;
    logic [W-1:0]  opb_q, opb_d;   // multiplier (shifts right) or divisor
    logic [W-1:0]  dq_q, dq_d;     // dividend shifting out, quotient in
    logic [W:0]    rem_q, rem_d;
    logic [IW-1:0] it_q, it_d;
    logic [W-1:0]  rmag_q, rmag_d;
    logic          rneg_q, rneg_d, rval_q, rval_d;
    logic          rzero_q, rzero_d, rdivz_q, rdivz_d, rovf_q, rovf_d;
    logic          in_ready, busy;

    function automatic logic [SW-1:0] to_s(input logic [W-1:0] m,
                                           input logic n);
        logic [SW-1:0] e;
        e = {2'b00, m};
        return n ? (~e + SW'(1)) : e;
    endfunction

    logic          xfer, tok_last, div_ge;
    logic [SW-1:0] tabs, opnd, fold_r, fold_abs;
    logic [PW-1:0] mul_sum;
    logic [W:0]    div_sh;
    logic [W-1:0]  div_q, dvd;

    assign xfer     = bus.IN_VALID && in_ready && !bus.CLEAR;
    // the N_OPS-th operand closes the expression even without IN_LAST
    assign tok_last = bus.IN_LAST || (cnt_q + 4'd1 == NOPS);
    assign tabs     = term_q[SW-1] ? (~term_q + SW'(1)) : term_q;
    assign opnd     = to_s(bus.IN_MAG, bus.IN_NEG ^ (bus.IN_OP == OP_SUB));
    assign mul_sum  = acc_q + (opb_q[0] ? mcand_q : '0);
    assign div_sh   = {rem_q[W-1:0], dq_q[W-1]};
    assign div_ge   = div_sh >= {1'b0, opb_q};
    assign div_q    = {dq_q[W-2:0], div_ge};
    assign fold_r   = sum_q + term_q;
    assign fold_abs = fold_r[SW-1] ? (~fold_r + SW'(1)) : fold_r;
    // a left-to-right chain can exceed W bits before a divide; clip it
    assign dvd      = (tabs > SW'(MAXV)) ? MAXV : tabs[W-1:0];

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.CLEAR) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:
                    if (xfer) state_d = bus.IN_LAST ? S_FOLD : S_ACCEPT;
                S_ACCEPT:
                    if (xfer) begin
                        if (bus.IN_OP == OP_MUL)      state_d = S_MUL;
                        else if (bus.IN_OP == OP_DIV) state_d = S_DIV;
                        else if (tok_last)            state_d = S_FOLD;
                    end
                S_MUL:
                    if (it_q == ITL) state_d = last_q ? S_FOLD : S_ACCEPT;
                S_DIV:
                    if (opb_q == '0 || it_q == ITL)
                        state_d = last_q ? S_FOLD : S_ACCEPT;
                S_FOLD:  state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready = (state_q == S_IDLE) || (state_q == S_ACCEPT);
        busy     = (state_q != S_IDLE);
    end

    always_comb begin
        sum_d   = sum_q;
        term_d  = term_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        neg_d   = neg_q;
        divz_d  = divz_q;
        ovf_d   = ovf_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        opb_d   = opb_q;
        dq_d    = dq_q;
        rem_d   = rem_q;
        it_d    = it_q;
        rmag_d  = rmag_q;
        rneg_d  = rneg_q;
        rzero_d = rzero_q;
        rdivz_d = rdivz_q;
        rovf_d  = rovf_q;
        rval_d  = 1'b0;
        unique case (state_q)
            S_IDLE:
                if (xfer) begin
                    term_d = to_s(bus.IN_MAG, bus.IN_NEG);
                    sum_d  = '0;
                    cnt_d  = 4'd1;
                    divz_d = 1'b0;
                    ovf_d  = 1'b0;
                end
            S_ACCEPT:
                if (xfer) begin
                    cnt_d  = cnt_q + 4'd1;
                    last_d = tok_last;
                    it_d   = '0;
                    neg_d  = term_q[SW-1] ^ bus.IN_NEG;
                    opb_d  = bus.IN_MAG;
                    unique case (bus.IN_OP)
                        OP_ADD, OP_SUB:
                            if (PREC_EN) begin
                                sum_d  = sum_q + term_q;
                                term_d = opnd;
                            end else begin
                                term_d = term_q + opnd;
                            end
                        OP_MUL: begin
                            acc_d   = '0;
                            mcand_d = PW'(tabs);
                        end
                        default: begin
                            rem_d = '0;
                            dq_d  = dvd;
                            ovf_d = ovf_q | (tabs > SW'(MAXV));
                        end
                    endcase
                end
            S_MUL: begin
                acc_d   = mul_sum;
                mcand_d = mcand_q << 1;
                opb_d   = opb_q >> 1;
                it_d    = it_q + IW'(1);
                if (it_q == ITL) begin
                    if (mul_sum > PW'(MAXV)) begin
                        term_d = to_s(MAXV, neg_q);
                        ovf_d  = 1'b1;
                    end else begin
                        term_d = to_s(mul_sum[W-1:0], neg_q);
                    end
                end
            end
            S_DIV:
                if (opb_q == '0) begin
                    term_d = to_s(MAXV, neg_q);
                    divz_d = 1'b1;
                end else begin
                    rem_d = div_ge ? div_sh - {1'b0, opb_q} : div_sh;
                    dq_d  = div_q;
                    it_d  = it_q + IW'(1);
                    if (it_q == ITL) term_d = to_s(div_q, neg_q);
                end
            S_FOLD:
                if (fold_abs > SW'(MAXV)) begin
                    term_d = to_s(MAXV, fold_r[SW-1]);
                    ovf_d  = 1'b1;
                end else begin
                    term_d = fold_r;
                end
            S_DONE:
                if (!bus.CLEAR) begin
                    rmag_d  = tabs[W-1:0];
                    rneg_d  = term_q[SW-1];
                    rzero_d = (term_q == '0);
                    rdivz_d = divz_q;
                    rovf_d  = ovf_q;
                    rval_d  = 1'b1;
                end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sum_q   <= '0;
            term_q  <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            neg_q   <= 1'b0;
            divz_q  <= 1'b0;
            ovf_q   <= 1'b0;
            acc_q   <= '0;
            mcand_q <= '0;
            opb_q   <= '0;
            dq_q    <= '0;
            rem_q   <= '0;
            it_q    <= '0;
            rmag_q  <= '0;
            rneg_q  <= 1'b0;
            rzero_q <= 1'b0;
            rdivz_q <= 1'b0;
            rovf_q  <= 1'b0;
            rval_q  <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            term_q  <= term_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            neg_q   <= neg_d;
            divz_q  <= divz_d;
            ovf_q   <= ovf_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            opb_q   <= opb_d;
            dq_q    <= dq_d;
            rem_q   <= rem_d;
            it_q    <= it_d;
            rmag_q  <= rmag_d;
            rneg_q  <= rneg_d;
            rzero_q <= rzero_d;
            rdivz_q <= rdivz_d;
            rovf_q  <= rovf_d;
            rval_q  <= rval_d;
        end
    end

    assign bus.IN_READY  = in_ready;
    assign bus.BUSY      = busy;
    assign bus.RES_MAG   = rmag_q;
    assign bus.RES_NEG   = rneg_q;
    assign bus.RES_VALID = rval_q;
    assign bus.FLAG_ZERO = rzero_q;
    assign bus.FLAG_DIVZ = rdivz_q;
    assign bus.FLAG_OVF  = rovf_q;
endmodule

// File: tb/tb_seq_expr_calc.sv
// tb_seq_expr_calc: scoreboard bench for seq_expr_calc (W=8, N_OPS=5).
// Two DUTs share all inputs: one with precedence, one left-to-right.
module tb_seq_expr_calc;
    localparam int W = 8;
    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] SUB = 2'b01;
    localparam logic [1:0] MUL = 2'b10;
    localparam logic [1:0] DIV = 2'b11;

    typedef struct packed {
        logic [W-1:0] mag;
        logic         neg;
        logic         zero;
        logic         divz;
        logic         ovf;
    } res_t;

    typedef struct {
        res_t r;
        int   lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t sb[$];

    seq_expr_calc_if #(.W(W)) bp ();
    seq_expr_calc_if #(.W(W)) bn ();

    seq_expr_calc #(.W(W), .N_OPS(5), .PREC_EN(1'b1)) u_dut (
        .CLOCK_50(clk),
        .RESET_N (rst_n),
        .bus     (bp)
    );

    seq_expr_calc #(.W(W), .N_OPS(5), .PREC_EN(1'b0)) u_dut_ltr (
        .CLOCK_50(clk),
        .RESET_N (rst_n),
        .bus     (bn)
    );

    assign bn.CLEAR    = bp.CLEAR;
    assign bn.IN_VALID = bp.IN_VALID;
    assign bn.IN_MAG   = bp.IN_MAG;
    assign bn.IN_NEG   = bp.IN_NEG;
    assign bn.IN_OP    = bp.IN_OP;
    assign bn.IN_LAST  = bp.IN_LAST;

    always #5 clk = ~clk;

    function automatic res_t got_res();
        return {bp.RES_MAG, bp.RES_NEG, bp.FLAG_ZERO,
                bp.FLAG_DIVZ, bp.FLAG_OVF};
    endfunction

    function automatic exp_t mk(input logic [W-1:0] m, input logic n,
                                input logic z, input logic dz,
                                input logic ov, input int lat);
        exp_t e;
        e.r   = {m, n, z, dz, ov};
        e.lat = lat;
        return e;
    endfunction

    // drive one token and hold it until it transfers (bounded)
    task automatic send(input logic [W-1:0] m, input logic n,
                        input logic [1:0] op, input logic last);
        int w = 0;
        bp.IN_MAG   = m;
        bp.IN_NEG   = n;
        bp.IN_OP    = op;
        bp.IN_LAST  = last;
        bp.IN_VALID = 1'b1;
        while (!bp.IN_READY && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        if (!bp.IN_READY) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: IN_READY=%0b, required 1", bp.IN_READY);
        end
        @(posedge clk); #1;
        bp.IN_VALID = 1'b0;
        bp.IN_LAST  = 1'b0;
    endtask

    // cycles from the last transfer until RES_VALID is seen
    task automatic wait_res(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bp.RES_VALID && lat < 200);
    endtask

    task automatic test_reset();
        bp.CLEAR    = 1'b0;
        bp.IN_VALID = 1'b0;
        bp.IN_MAG   = '0;
        bp.IN_NEG   = 1'b0;
        bp.IN_OP    = ADD;
        bp.IN_LAST  = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (got_res() !== res_t'(0) || bp.RES_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h/%b, required 0/0", got_res(), bp.RES_VALID);
        end
        n_tests++;
        if ({bp.BUSY, bp.IN_READY} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_busy_ready: got %b, required 01", {bp.BUSY, bp.IN_READY});
        end
    endtask

    task automatic test_precedence();
        int   lat;
        exp_t e;
        send(8'd3, 1'b0, ADD, 1'b0);
        send(8'd2, 1'b0, ADD, 1'b0);
        sb.push_back(mk(8'd11, 1'b0, 1'b0, 1'b0, 1'b0, 10));
        send(8'd4, 1'b0, MUL, 1'b1);
        wait_res(lat);
        e = sb.pop_front();
        n_tests++;
        if (got_res() !== e.r || lat != e.lat) begin
            n_fail++;
            $display("FAIL prec_3p2x4: got %h lat %0d, required %h lat %0d", got_res(), lat, e.r, e.lat);
        end
        n_tests++;
        if (bn.RES_MAG !== 8'd20 || bn.RES_VALID !== 1'b1) begin
            n_fail++;
            $display("FAIL ltr_3p2x4: got %0d valid %b, required 20 valid 1", bn.RES_MAG, bn.RES_VALID);
        end
    endtask

    task automatic test_div_zero_result();
        int   lat;
        exp_t e;
        send(8'd7, 1'b1, ADD, 1'b0);
        sb.push_back(mk(8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 10));
        send(8'd2, 1'b0, DIV, 1'b1);
        wait_res(lat);
        e = sb.pop_front();
        n_tests++;
        if (got_res() !== e.r || lat != e.lat) begin
            n_fail++;
            $display("FAIL div_m7_2: got %h lat %0d, required %h lat %0d", got_res(), lat, e.r, e.lat);
        end
        send(8'd3, 1'b0, ADD, 1'b0);
        sb.push_back(mk(8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2));
        send(8'd3, 1'b0, SUB, 1'b1);
        wait_res(lat);
        e = sb.pop_front();
        n_tests++;
        if (got_res() !== e.r || lat != e.lat) begin
            n_fail++;
            $display("FAIL sub_to_zero: got %h lat %0d, required %h lat %0d", got_res(), lat, e.r, e.lat);
        end
    endtask

    task automatic test_divz();
        int   lat;
        exp_t e;
        send(8'd5, 1'b0, ADD, 1'b0);
        sb.push_back(mk(8'd255, 1'b0, 1'b0, 1'b1, 1'b0, 3));
        send(8'd0, 1'b0, DIV, 1'b1);
        wait_res(lat);
        e = sb.pop_front();
        n_tests++;
        if (got_res() !== e.r || lat != e.lat) begin
            n_fail++;
            $display("FAIL divz: got %h lat %0d, required %h lat %0d", got_res(), lat, e.r, e.lat);
        end
        send(8'd1, 1'b0, ADD, 1'b0);
        sb.push_back(mk(8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2));
        send(8'd1, 1'b0, ADD, 1'b1);
        wait_res(lat);
        e = sb.pop_front();
        n_tests++;
        if (got_res() !== e.r || lat != e.lat) begin
            n_fail++;
            $display("FAIL divz_cleared: got %h lat %0d, required %h lat %0d", got_res(), lat, e.r, e.lat);
        end
    endtask

    task automatic test_ovf();
        int   lat;
        exp_t e;
        send(8'd200, 1'b0, ADD, 1'b0);
        sb.push_back(mk(8'd255, 1'b0, 1'b0, 1'b0, 1'b1, 10));
        send(8'd2, 1'b0, MUL, 1'b1);
        wait_res(lat);
        e = sb.pop_front();
        n_tests++;
        if (got_res() !== e.r || lat != e.lat) begin
            n_fail++;
            $display("FAIL mul_sat: got %h lat %0d, required %h lat %0d", got_res(), lat, e.r, e.lat);
        end
        send(8'd250, 1'b0, ADD, 1'b0);
        sb.push_back(mk(8'd255, 1'b0, 1'b0, 1'b0, 1'b1, 2));
        send(8'd10, 1'b0, ADD, 1'b1);
        wait_res(lat);
        e = sb.pop_front();
        n_tests++;
        if (got_res() !== e.r || lat != e.lat) begin
            n_fail++;
            $display("FAIL add_sat: got %h lat %0d, required %h lat %0d", got_res(), lat, e.r, e.lat);
        end
    endtask

    task automatic test_auto_finish();
        int   lat;
        exp_t e;
        for (int i = 1; i <= 4; i++) send(W'(i), 1'b0, ADD, 1'b0);
        sb.push_back(mk(8'd15, 1'b0, 1'b0, 1'b0, 1'b0, 2));
        send(8'd5, 1'b0, ADD, 1'b0);
        bp.IN_MAG   = 8'd6;
        bp.IN_OP    = ADD;
        bp.IN_VALID = 1'b1;
        n_tests++;
        if (bp.IN_READY !== 1'b0) begin
            n_fail++;
            $display("FAIL auto_ready: IN_READY=%b, required 0", bp.IN_READY);
        end
        wait_res(lat);
        bp.IN_VALID = 1'b0;
        e = sb.pop_front();
        n_tests++;
        if (got_res() !== e.r || lat != e.lat) begin
            n_fail++;
            $display("FAIL auto_sum: got %h lat %0d, required %h lat %0d", got_res(), lat, e.r, e.lat);
        end
    endtask

    task automatic test_clear();
        int   lat;
        exp_t e;
        send(8'd9, 1'b0, ADD, 1'b0);
        sb.push_back(mk(8'd10, 1'b0, 1'b0, 1'b0, 1'b0, 2));
        send(8'd1, 1'b0, ADD, 1'b1);
        wait_res(lat);
        e = sb.pop_front();
        n_tests++;
        if (got_res() !== e.r || lat != e.lat) begin
            n_fail++;
            $display("FAIL pre_clear: got %h lat %0d, required %h lat %0d", got_res(), lat, e.r, e.lat);
        end
        send(8'd4, 1'b0, ADD, 1'b0);
        bp.CLEAR    = 1'b1;
        bp.IN_MAG   = 8'd7;
        bp.IN_LAST  = 1'b1;
        bp.IN_VALID = 1'b1;
        @(posedge clk); #1;
        bp.CLEAR    = 1'b0;
        bp.IN_VALID = 1'b0;
        bp.IN_LAST  = 1'b0;
        n_tests++;
        if ({bp.BUSY, bp.RES_VALID, bp.RES_MAG} !== {2'b00, 8'd10}) begin
            n_fail++;
            $display("FAIL clear_accept: busy %b valid %b mag %0d, required 0 0 10", bp.BUSY, bp.RES_VALID, bp.RES_MAG);
        end
        send(8'd2, 1'b0, ADD, 1'b0);
        sb.push_back(mk(8'd6, 1'b0, 1'b0, 1'b0, 1'b0, 10));
        send(8'd3, 1'b0, MUL, 1'b1);
        wait_res(lat);
        e = sb.pop_front();
        n_tests++;
        if (got_res() !== e.r || lat != e.lat) begin
            n_fail++;
            $display("FAIL post_clear: got %h lat %0d, required %h lat %0d", got_res(), lat, e.r, e.lat);
        end
    endtask

    task automatic test_reset_mid_div();
        int   lat;
        exp_t e;
        send(8'd100, 1'b0, ADD, 1'b0);
        send(8'd3, 1'b0, DIV, 1'b1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if (got_res() !== res_t'(0) || bp.RES_VALID !== 1'b0 ||
            {bp.BUSY, bp.IN_READY} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_mid_div: got %h busy %b ready %b, required 0 0 1", got_res(), bp.BUSY, bp.IN_READY);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        send(8'd8, 1'b0, ADD, 1'b0);
        sb.push_back(mk(8'd4, 1'b0, 1'b0, 1'b0, 1'b0, 10));
        send(8'd2, 1'b0, DIV, 1'b1);
        wait_res(lat);
        e = sb.pop_front();
        n_tests++;
        if (got_res() !== e.r || lat != e.lat) begin
            n_fail++;
            $display("FAIL after_reset: got %h lat %0d, required %h lat %0d", got_res(), lat, e.r, e.lat);
        end
    endtask

    task automatic test_back_to_back();
        int got_n = 0;
        fork
            begin
                send(8'd4, 1'b1, ADD, 1'b0);
                sb.push_back(mk(8'd20, 1'b0, 1'b0, 1'b0, 1'b0, 0));
                send(8'd5, 1'b1, MUL, 1'b1);
                send(8'd4, 1'b1, ADD, 1'b0);
                sb.push_back(mk(8'd10, 1'b1, 1'b0, 1'b0, 1'b0, 0));
                send(8'd6, 1'b0, SUB, 1'b1);
                send(8'd7, 1'b0, ADD, 1'b0);
                send(8'd3, 1'b0, MUL, 1'b0);
                send(8'd1, 1'b0, ADD, 1'b0);
                sb.push_back(mk(8'd21, 1'b0, 1'b0, 1'b0, 1'b0, 0));
                send(8'd2, 1'b0, DIV, 1'b1);
            end
            begin
                exp_t e;
                for (int c = 0; c < 600 && got_n < 3; c++) begin
                    @(posedge clk); #1;
                    if (bp.RES_VALID) begin
                        got_n++;
                        n_tests++;
                        if (sb.size() == 0) begin
                            n_fail++;
                            $display("FAIL b2b_unexpected: got %h, required none", got_res());
                        end else begin
                            e = sb.pop_front();
                            if (got_res() !== e.r) begin
                                n_fail++;
                                $display("FAIL b2b_result%0d: got %h, required %h", got_n, got_res(), e.r);
                            end
                        end
                    end
                end
            end
        join
        n_tests++;
        if (got_n != 3 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d results %0d left, required 3 and 0", got_n, sb.size());
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_precedence();
        test_div_zero_result();
        test_divz();
        test_ovf();
        test_auto_finish();
        test_clear();
        test_reset_mid_div();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
